fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 66 ++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC and the IF/ID pipeline register.
// Decode can stall it or redirect it on a taken branch or jump; a bad target raises a sticky error.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] InstReg,
    output logic [31:0] Pc,
    output logic [31:0] IfIdInst,
    output logic [31:0] IfIdPcPlus4,
    output logic        IfIdValid,
    output logic        AddrError
);

    // The mask keeps a word-aligned address inside instruction memory (IMEM_WORDS is a power of two).
    localparam logic [32:0] MEM_BYTES = 33'(IMEM_WORDS) << 2;
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 33'd4);

    logic [31:0] pc_plus4;
    logic [31:0] seq_next;
    logic [31:0] jump_target;
    logic [31:0] redirect_raw;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        redirect_bad;

    assign pc_plus4     = Pc + 32'd4;
    assign seq_next     = pc_plus4 & ADDR_MASK;
    assign jump_target  = {IfIdPcPlus4[31:28], JumpIndex, 2'b00};
    assign redirect     = BranchTaken | Jump;
    // A branch always beats a simultaneous jump, so only the winner's target is checked.
    assign redirect_raw = BranchTaken ? BranchTarget : jump_target;
    assign redirect_pc  = redirect_raw & ADDR_MASK;
    assign redirect_bad = (redirect_raw[1:0] != 2'b00) || ({1'b0, redirect_raw} >= MEM_BYTES);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Pc          <= RESET_PC;
            IfIdInst    <= 32'h0;
            IfIdPcPlus4 <= 32'h0;
            IfIdValid   <= 1'b0;
            AddrError   <= 1'b0;
        end else if (redirect) begin
            // Redirects flush IF/ID even while stalled, leaving one bubble.
            Pc          <= redirect_pc;
            IfIdInst    <= 32'h0;
            IfIdPcPlus4 <= 32'h0;
            IfIdValid   <= 1'b0;
            if (redirect_bad)
                AddrError <= 1'b1;
        end else if (!Stall) begin
            Pc          <= seq_next;
            IfIdInst    <= InstReg;
            IfIdPcPlus4 <= pc_plus4;
            IfIdValid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural model pushes expected IF state to a
// scoreboard queue each cycle, and the DUT outputs are popped and compared after the edge.
module tb_fetch_unit;

    localparam logic [31:0] MEM_BYTES = 32'd4096;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        Jump = 1'b0;
    logic [25:0] JumpIndex = 26'h0;
    logic [31:0] InstReg;
    logic [31:0] Pc;
    logic [31:0] IfIdInst;
    logic [31:0] IfIdPcPlus4;
    logic        IfIdValid;
    logic        AddrError;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
        .InstReg(InstReg), .Pc(Pc), .IfIdInst(IfIdInst), .IfIdPcPlus4(IfIdPcPlus4),
        .IfIdValid(IfIdValid), .AddrError(AddrError)
    );

    always #5 Clk = ~Clk;

    // Instruction memory: word n holds 32'h1000_0000 + n.
    assign InstReg = 32'h1000_0000 + {2'b00, Pc[31:2]};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_err;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                                 input logic [31:0] tgt, input logic jmp, input logic [25:0] idx);
        exp_t e;
        logic [31:0] raw;
        Reset = rst; Stall = stall; BranchTaken = br; BranchTarget = tgt;
        Jump = jmp; JumpIndex = idx;
        if (rst) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        end else if (br || jmp) begin
            raw = br ? tgt : {m_pc4[31:28], idx, 2'b00};
            if ((raw % 32'd4) != 32'd0 || raw >= MEM_BYTES)
                m_err = 1'b1;
            m_pc = (raw - (raw % 32'd4)) % MEM_BYTES;
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            m_inst  = 32'h1000_0000 + m_pc / 32'd4;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = (m_pc + 32'd4) % MEM_BYTES;
        end
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.err = m_err;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        checkOutput("pc", Pc, e.pc);
        checkOutput("ifid_inst", IfIdInst, e.inst);
        checkOutput("ifid_pc4", IfIdPcPlus4, e.pc4);
        checkOutput("ifid_valid", 32'(IfIdValid), 32'(e.valid));
        checkOutput("addr_error", 32'(AddrError), 32'(e.err));
    endtask

    task automatic step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    initial begin
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        @(negedge Clk);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        checkOutput("rst_pc", Pc, 32'h0);
        checkOutput("rst_valid", 32'(IfIdValid), 32'h0);

        step();
        checkOutput("seq1_inst", IfIdInst, 32'h1000_0000);
        checkOutput("seq1_valid", 32'(IfIdValid), 32'h1);
        step();
        checkOutput("seq2_pc", Pc, 32'h8);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        checkOutput("stall_pc", Pc, 32'h8);
        checkOutput("stall_inst", IfIdInst, 32'h1000_0001);
        step();
        checkOutput("release_pc", Pc, 32'hC);
        checkOutput("release_inst", IfIdInst, 32'h1000_0002);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 26'h0);
        checkOutput("br_pc", Pc, 32'h40);
        checkOutput("br_valid", 32'(IfIdValid), 32'h0);
        step();
        checkOutput("br_inst", IfIdInst, 32'h1000_0010);
        checkOutput("br_pc4", IfIdPcPlus4, 32'h44);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 26'h10);
        checkOutput("brjmp_pc", Pc, 32'h20);
        checkOutput("brjmp_err", 32'(AddrError), 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFC, 1'b0, 26'h0);
        step();
        checkOutput("wrap_pc", Pc, 32'h0);
        checkOutput("wrap_pc4", IfIdPcPlus4, 32'h1000);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 26'h0);
        checkOutput("mis_pc", Pc, 32'h40);
        checkOutput("mis_err", 32'(AddrError), 32'h1);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF);
        checkOutput("jmp_mask_pc", Pc, 32'hFFC);
        checkOutput("err_sticky", 32'(AddrError), 32'h1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 26'h0);
        checkOutput("rstbr_pc", Pc, 32'h0);
        checkOutput("rstbr_err", 32'(AddrError), 32'h0);
        step();
        checkOutput("post_rst_inst", IfIdInst, 32'h1000_0000);

        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10);
        checkOutput("jmp_pc", Pc, 32'h40);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] tgt;
            r = int'($urandom_range(0, 99));
            tgt = 32'($urandom_range(0, 5119));
            if ($urandom_range(0, 3) != 0)
                tgt = tgt & ~32'd3;
            applyStimulus(r == 0, $urandom_range(0, 3) == 0, r >= 1 && r <= 8, tgt,
                          r >= 6 && r <= 14, 26'($urandom_range(0, 1100)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
